// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the VGA framebuffer arbiter.
package vga_fb_pkg;

  // Owner of the SRAM port for the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } grant_t;

  // Linear framebuffer word address of pixel (x, y) for a row pitch.
  function automatic logic [31:0] pix_addr(input logic [31:0] px,
                                           input logic [31:0] py,
                                           input logic [31:0] pitch);
    return py * pitch + px;
  endfunction

endpackage

// File: rtl/vga_pix_slot_counter.sv
// Divides clk into pixel periods of PIX_DIV cycles and flags the slots the
// arbiter cares about: the last slot (pixel advance), slot 0 and slot 1.
module vga_pix_slot_counter #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic inc,
  output logic slot_first,
  output logic slot_cap
);

  localparam int SLOT_BITS = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [SLOT_BITS-1:0] SLOT_LAST = SLOT_BITS'(PIX_DIV - 1);
  localparam logic [SLOT_BITS-1:0] SLOT_ONE  = SLOT_BITS'(1);

  logic [SLOT_BITS-1:0] slot;

  // Free-running slot counter, wraps after the last slot of the period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot <= '0;
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
    end else begin
      slot <= slot + SLOT_ONE;
    end
  end

  assign inc        = (slot == SLOT_LAST);
  assign slot_first = (slot == '0);
  assign slot_cap   = (slot == SLOT_ONE);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer SRAM between the display fetch (slot 0
// of every pixel period) and a writer (all other slots).
// Build option: define VGA_FB_ARB_BLANK_WR_EN to hand blanked slot 0 to the
// writer as well; by default a blanked slot 0 stays idle.
//
// grant    | meaning
// GNT_NONE | nobody drives the SRAM (reset, or blanked slot 0)
// GNT_DISP | display read of the current pixel
// GNT_WR   | writer owns the SRAM; a write occurs if wr_valid
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int PIX_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int X_BITS    = 10,
  parameter int Y_BITS    = 10,
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 inc,
  input  logic [X_BITS-1:0]    x,
  input  logic [Y_BITS-1:0]    y,
  input  logic                 visible,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic                 sram_we,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata,
  output logic                 pix_valid,
  output logic [DATA_BITS-1:0] pix_data
);

  if (PIX_DIV < 2 || H_VISIBLE < 1 || V_VISIBLE < 1) begin : g_bad_param
    $error("vga_fb_arbiter: PIX_DIV must be >= 2 and frame size non-zero");
  end

  grant_t               grant;
  logic                 slot_first;
  logic                 slot_cap;
  logic                 wr_xfer;
  logic                 disp_q;
  logic [ADDR_BITS-1:0] disp_addr;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] wdata_q;

  vga_pix_slot_counter #(
    .PIX_DIV(PIX_DIV)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .slot_first(slot_first),
    .slot_cap  (slot_cap)
  );

  assign disp_addr = ADDR_BITS'(pix_addr(32'(x), 32'(y), 32'(H_VISIBLE)));

  // Grant decode; reset is folded in so outputs drop in the same cycle.
  always_comb begin
    grant = GNT_WR;
    if (!reset) begin
      grant = GNT_NONE;
    end else if (slot_first) begin
      if (visible) begin
        grant = GNT_DISP;
      end else begin
`ifdef VGA_FB_ARB_BLANK_WR_EN
        grant = GNT_WR;
`else
        grant = GNT_NONE;
`endif
      end
    end
  end

  // wr_ready depends on the slot only, so there is no path from wr_valid.
  assign wr_ready  = (grant == GNT_WR);
  assign wr_xfer   = wr_ready && wr_valid;
  assign sram_we   = wr_xfer;
  assign pix_valid = slot_cap;

  // SRAM port mux; idle cycles keep presenting the last address and data.
  always_comb begin
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    if (grant == GNT_DISP) begin
      sram_addr = disp_addr;
    end else if (wr_xfer) begin
      sram_addr  = wr_addr;
      sram_wdata = wr_data;
    end
  end

  // Remember what the SRAM port last carried for the hold-on-idle behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= sram_addr;
      wdata_q <= sram_wdata;
    end
  end

  // Note at slot 0 whether a real display read was issued this period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= 1'b0;
    end else if (slot_first) begin
      disp_q <= (grant == GNT_DISP);
    end
  end

  // Capture read data in slot 1, or black when slot 0 was blanked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_data <= '0;
    end else if (slot_cap) begin
      pix_data <= disp_q ? sram_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter (PIX_DIV=4, pitch 640) plus a short
// randomised writer run over a reduced frame against an SRAM model.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

`ifdef VGA_FB_ARB_BLANK_WR_EN
  localparam bit BLANK_WR = 1'b1;
`else
  localparam bit BLANK_WR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        inc;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        visible;
  logic        wr_valid;
  logic        wr_ready;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [19:0] sram_addr;
  logic        sram_we;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        pix_valid;
  logic [15:0] pix_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:4095];
  logic [15:0] rd_next;
  logic [15:0] exp_pix;
  logic        exp_ready;
  logic        drop_wr;
  int          we_cnt;
  int          issued, accepted, stray, lost, xfer_bad;
  int          ready_bad, pv_bad, inc_bad, disp_reads;
  logic [31:0] exp_addr;

  vga_fb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .inc       (inc),
    .x         (x),
    .y         (y),
    .visible   (visible),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sram_addr (sram_addr),
    .sram_we   (sram_we),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .pix_valid (pix_valid),
    .pix_data  (pix_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 3 after.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset      = 1'b0;
    x          = 10'd5;
    y          = 10'd2;
    visible    = 1'b1;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    sram_rdata = '0;

    // Reset state
    repeat (3) next_cycle();
    settle();
    check("rst_inc", inc, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_valid", pix_valid, 0);

    // 1: release; this cycle is slot 0
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      settle();
      check($sformatf("t1_inc_c%0d", i), inc, (i % 4 == 3) ? 1 : 0);
      check($sformatf("t1_ready_c%0d", i), wr_ready, (i % 4 != 0) ? 1 : 0);
      check($sformatf("t1_we_c%0d", i), sram_we, 0);
      next_cycle();
    end

    // 2: display fetch of (5,2)
    settle();
    check("t2_addr", sram_addr, 1285);
    check("t2_we", sram_we, 0);
    next_cycle();
    sram_rdata = 16'hBEEF;
    settle();
    check("t2_pix_valid", pix_valid, 1);
    next_cycle();
    settle();
    check("t2_pix_data", pix_data, 16'hBEEF);
    check("t2_pix_valid_off", pix_valid, 0);
    next_cycle();
    next_cycle();

    // 3: single write, then held valid
    wr_valid = 1'b1;
    wr_addr  = 20'd100;
    wr_data  = 16'h1234;
    settle();
    check("t3_s0_ready", wr_ready, 0);
    check("t3_s0_we", sram_we, 0);
    check("t3_s0_addr", sram_addr, 1285);
    next_cycle();
    settle();
    check("t3_s1_we", sram_we, 1);
    check("t3_s1_addr", sram_addr, 100);
    check("t3_s1_wdata", sram_wdata, 16'h1234);
    next_cycle();
    wr_valid = 1'b0;
    settle();
    check("t3_s2_we", sram_we, 0);
    check("t3_s2_addr_hold", sram_addr, 100);
    next_cycle();
    settle();
    check("t3_s3_we", sram_we, 0);
    next_cycle();
    wr_valid = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (sram_we) we_cnt++;
      next_cycle();
    end
    wr_valid = 1'b0;
    check("t3_held_writes", we_cnt, 3);

    // 4: blanked slot 0
    x        = 10'd700;
    visible  = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 20'd200;
    wr_data  = 16'h5555;
    settle();
`ifdef VGA_FB_ARB_BLANK_WR_EN
    check("t4_s0_ready", wr_ready, 1);
    check("t4_s0_we", sram_we, 1);
    check("t4_s0_addr", sram_addr, 200);
    next_cycle();
    wr_valid = 1'b0;
    settle();
`else
    check("t4_s0_ready", wr_ready, 0);
    check("t4_s0_we", sram_we, 0);
    next_cycle();
    settle();
    check("t4_s1_we", sram_we, 1);
    check("t4_s1_addr", sram_addr, 200);
`endif
    check("t4_pix_valid", pix_valid, 1);
    next_cycle();
    wr_valid = 1'b0;
    settle();
    check("t4_pix_black", pix_data, 0);
    next_cycle();
    next_cycle();

    // 5: reset asserted in slot 2 mid-write
    x       = 10'd5;
    visible = 1'b1;
    next_cycle();
    next_cycle();
    wr_valid = 1'b1;
    wr_addr  = 20'd300;
    wr_data  = 16'h0A0A;
    settle();
    check("t5_pre_we", sram_we, 1);
    reset = 1'b0;
    #1;
    check("t5_rst_we", sram_we, 0);
    check("t5_rst_ready", wr_ready, 0);
    check("t5_rst_pix", pix_data, 0);
    check("t5_rst_addr", sram_addr, 0);
    check("t5_rst_inc", inc, 0);
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) wr_valid = 1'b0;
      settle();
      check($sformatf("t5_inc_c%0d", i), inc, (i == 3) ? 1 : 0);
      check($sformatf("t5_ready_c%0d", i), wr_ready, (i != 0) ? 1 : 0);
      if (i == 1) begin
        check("t5_replay_we", sram_we, 1);
        check("t5_replay_addr", sram_addr, 300);
      end
      if (i == 2) check("t5_pix_after", pix_data, 16'hBEEF);
      next_cycle();
    end

    // 6: random writer over a reduced frame (16x4 visible inside 20x6)
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rd_next = '0; exp_pix = '0; drop_wr = 1'b0;
    issued = 0; accepted = 0; stray = 0; lost = 0; xfer_bad = 0;
    ready_bad = 0; pv_bad = 0; inc_bad = 0; disp_reads = 0;
    for (int py = 0; py < 6; py++) begin
      for (int px = 0; px < 20; px++) begin
        for (int s = 0; s < 4; s++) begin
          if (s == 0) begin
            x       = 10'(px);
            y       = 10'(py);
            visible = (px < 16) && (py < 4);
          end
          sram_rdata = rd_next;
          if (drop_wr) wr_valid = 1'b0;
          drop_wr = 1'b0;
          if (!wr_valid && ($urandom_range(1) == 1)) begin
            wr_valid = 1'b1;
            wr_addr  = 20'(pix_addr(32'($urandom_range(15)), 32'($urandom_range(3)), 32'd640));
            wr_data  = 16'($urandom);
            issued++;
          end
          settle();
          exp_ready = (s != 0) || (!visible && BLANK_WR);
          if (wr_ready !== exp_ready) ready_bad++;
          if (pix_valid !== (s == 1)) pv_bad++;
          if (inc !== (s == 3)) inc_bad++;
          if (s == 0) begin
            if (visible) begin
              exp_addr = pix_addr(32'(px), 32'(py), 32'd640);
              check($sformatf("t6_disp_addr_%0d_%0d", px, py), sram_addr, exp_addr);
              exp_pix = mem[exp_addr[11:0]];
              disp_reads++;
            end else begin
              exp_pix = '0;
            end
          end
          if (s == 2) check($sformatf("t6_pix_%0d_%0d", px, py), pix_data, exp_pix);
          rd_next = mem[sram_addr[11:0]];
          if (sram_we) begin
            if (!(wr_valid && wr_ready)) begin
              stray++;
            end else begin
              if (sram_addr !== wr_addr || sram_wdata !== wr_data) xfer_bad++;
              mem[wr_addr[11:0]] = wr_data;
              accepted++;
              drop_wr = 1'b1;
            end
          end else if (wr_valid && wr_ready) begin
            lost++;
          end
          next_cycle();
        end
      end
    end
    if (drop_wr) wr_valid = 1'b0;
    check("t6_accepted", accepted, issued - (wr_valid ? 1 : 0));
    check("t6_stray", stray, 0);
    check("t6_lost", lost, 0);
    check("t6_xfer", xfer_bad, 0);
    check("t6_ready", ready_bad, 0);
    check("t6_pix_valid", pv_bad, 0);
    check("t6_inc", inc_bad, 0);
    check("t6_disp_reads", disp_reads, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
